// File: rtl/kim1_pkg.sv
// kim1_pkg: shared types and constants for the KIM-1 LED scan capture block.
//   seg_t        7-bit segment pattern, a..g in bits [0..6]
//   sel_t        4-bit digit/row select code from RRIOT port B
//   cap_state_t  capture FSM states
//   is_display() true for select codes that address one of the six digits
//   digit_idx()  digit slot index for a display select code
package kim1_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [3:0] sel_t;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HELD
   } cap_state_t;

   localparam int unsigned DIGIT_BASE = 4;
   localparam int unsigned NUM_DIGITS = 6;
   localparam int unsigned KEY_ROWS   = 3;
   localparam int unsigned KEY_COLS   = 7;
   localparam sel_t        SEL_NONE   = 4'hF;

   function automatic logic is_display(input sel_t s);
      return (s >= sel_t'(DIGIT_BASE)) && (s < sel_t'(DIGIT_BASE + NUM_DIGITS));
   endfunction

   function automatic logic [2:0] digit_idx(input sel_t s);
      sel_t d;
      d = s - sel_t'(DIGIT_BASE);
      return d[2:0];
   endfunction

endpackage

// File: rtl/kim1_digit_slot.sv
// kim1_digit_slot: one persistence-emulated display digit.
// Holds the captured segment pattern and a lit flag; the flag and pattern clear when the
// decay counter runs out without a fresh capture. A capture in the expiry cycle wins.
// Ports:
//   phi2     clock, rising edge
//   rst_n    asynchronous active-low reset
//   capture  load seg_in, light the digit and reload the decay counter
//   seg_in   segment pattern to capture
//   seg      captured segment pattern (0 when dark)
//   valid    digit currently lit
module kim1_digit_slot
   import kim1_pkg::*;
#(
   parameter int unsigned DECAY_CYCLES = 65536
) (
   input  logic phi2,
   input  logic rst_n,
   input  logic capture,
   input  seg_t seg_in,
   output seg_t seg,
   output logic valid
);

   localparam int unsigned CW = $clog2(DECAY_CYCLES + 1);

   seg_t          seg_q;
   logic          valid_q;
   logic [CW-1:0] decay_q;

   always_ff @(posedge phi2 or negedge rst_n) begin
      if (!rst_n) begin
         seg_q   <= '0;
         valid_q <= 1'b0;
         decay_q <= '0;
      end else if (capture) begin
         seg_q   <= seg_in;
         valid_q <= 1'b1;
         decay_q <= CW'(DECAY_CYCLES);
      end else if (decay_q != '0) begin
         decay_q <= decay_q - CW'(1);
         // Last tick of the persistence window: go dark.
         if (decay_q == CW'(1)) begin
            seg_q   <= '0;
            valid_q <= 1'b0;
         end
      end
   end

   assign seg   = seg_q;
   assign valid = valid_q;

endmodule

// File: rtl/kim1_led_capture.sv
// kim1_led_capture: decodes the KIM-1 multiplexed LED scan from the RRIOT port outputs and
// keeps a stable image of the six 7-segment digits for an external display driver.
// A digit is captured once select+segments have been stable long enough; captured digits
// fade out after DECAY_CYCLES without refresh.
// Optional build macro KIM1_KEYPAD_EN adds keypad row readback (keys in, pai out).
// Ports:
//   phi2          clock, rising edge
//   rst_n         asynchronous active-low reset
//   pao, ddra     RRIOT port A output register and direction (segments on [6:0])
//   pbo, ddrb     RRIOT port B output register and direction (select on [4:1])
//   seg_out       digit k segments at [7k+6:7k], digit 0 leftmost
//   digit_valid   digit k currently lit
//   frame_strobe  one-cycle pulse on each digit-5 capture
//   keys          (KIM1_KEYPAD_EN) key matrix, bit row*7+col, 1 = pressed
//   pai           (KIM1_KEYPAD_EN) row data toward RRIOT port A input, active low
module kim1_led_capture
   import kim1_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned DECAY_CYCLES  = 65536
) (
   input  logic        phi2,
   input  logic        rst_n,
   input  logic [7:0]  pao,
   input  logic [7:0]  ddra,
   input  logic [7:0]  pbo,
   input  logic [7:0]  ddrb,
   output logic [41:0] seg_out,
   output logic [5:0]  digit_valid,
   output logic        frame_strobe
`ifdef KIM1_KEYPAD_EN
   ,
   input  logic [20:0] keys,
   output logic [7:0]  pai
`endif
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES);

   // Select is only meaningful when all four select lines are driven.
   sel_t sel_raw;
   seg_t seg_raw;
   assign sel_raw = (ddrb[4:1] == 4'hF) ? pbo[4:1] : SEL_NONE;
   assign seg_raw = pao[6:0] & ddra[6:0];

   logic unused_port_bits;
   assign unused_port_bits = ^{pao[7], ddra[7], pbo[7:5], pbo[0], ddrb[7:5], ddrb[0]};

   sel_t          sel_q, sel_prev_q;
   seg_t          seg_q, seg_prev_q;
   cap_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          frame_q;

   logic changed, disp, stable_done;
   logic [NUM_DIGITS-1:0] cap_en;

   assign changed     = {sel_q, seg_q} != {sel_prev_q, seg_prev_q};
   assign disp        = is_display(sel_q);
   // This cycle's unchanged sample brings the counter to STABLE_CYCLES-1.
   assign stable_done = !changed && (cnt_q == CW'(STABLE_CYCLES - 2));

   always_ff @(posedge phi2 or negedge rst_n) begin
      if (!rst_n) begin
         sel_q      <= SEL_NONE;
         seg_q      <= '0;
         sel_prev_q <= SEL_NONE;
         seg_prev_q <= '0;
      end else begin
         sel_q      <= sel_raw;
         seg_q      <= seg_raw;
         sel_prev_q <= sel_q;
         seg_prev_q <= seg_q;
      end
   end

   // FSM state register
   always_ff @(posedge phi2 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         frame_q <= cap_en[NUM_DIGITS-1];
      end
   end

   // FSM next-state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (disp) state_d = SETTLE;
         end
         SETTLE: begin
            if (changed) begin
               cnt_d = '0;
               if (!disp) state_d = IDLE;
            end else if (stable_done) begin
               cnt_d   = CW'(STABLE_CYCLES - 1);
               state_d = HELD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HELD: begin
            if (changed) begin
               cnt_d   = '0;
               state_d = disp ? SETTLE : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM outputs: one-hot capture strobe to the addressed slot
   always_comb begin
      cap_en = '0;
      if (state_q == SETTLE && stable_done && disp) begin
         cap_en[digit_idx(sel_q)] = 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_slot
      kim1_digit_slot #(
         .DECAY_CYCLES(DECAY_CYCLES)
      ) u_slot (
         .phi2   (phi2),
         .rst_n  (rst_n),
         .capture(cap_en[k]),
         .seg_in (seg_q),
         .seg    (seg_out[7*k +: 7]),
         .valid  (digit_valid[k])
      );
   end

   assign frame_strobe = frame_q;

`ifdef KIM1_KEYPAD_EN
   logic [7:0] pai_q, pai_d;

   always_comb begin
      pai_d = 8'hFF;
      if (sel_q < sel_t'(KEY_ROWS)) begin
         pai_d = {1'b1, ~keys[int'(sel_q) * KEY_COLS +: KEY_COLS]};
      end
   end

   always_ff @(posedge phi2 or negedge rst_n) begin
      if (!rst_n) pai_q <= 8'hFF;
      else        pai_q <= pai_d;
   end

   assign pai = pai_q;
`endif

endmodule

// File: doc/kim1_led_capture.md
Name: kim1_led_capture

Overview:
Downstream consumer of the RRIOT port outputs on the KIM-1 board. Decodes the multiplexed LED scan that software drives on port A (segments) and port B (digit select). Latches a stable, persistence-emulated image of the six 7-segment digits for an external display driver. Optionally returns keypad row data toward the RRIOT port A input.

Parameters:
STABLE_CYCLES, 16, consecutive identical phi2 cycles of select+segments required before a digit is captured (>=2)
DECAY_CYCLES, 65536, phi2 cycles a captured digit stays lit without refresh before blanking (>=1)

Ports:
phi2  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
pao  in  8  RRIOT port A output register
ddra  in  8  RRIOT port A direction (1 = driven)
pbo  in  8  RRIOT port B output register
ddrb  in  8  RRIOT port B direction (1 = driven)
seg_out  out  42  digit k segments a..g at [7k+6:7k], digit 0 = leftmost
digit_valid  out  6  digit k currently lit
frame_strobe  out  1  one-cycle pulse on each digit-5 capture

Behaviour:
- Reset: phi2 and rst_n are the only clock/reset; reset is asynchronous, active-low. seg_out=0, digit_valid=0, frame_strobe=0, all counters 0, FSM IDLE.
- Effective select sel: pbo[4:1] when ddrb[4:1]==4'hF, else 4'hF (no select). Effective segments seg = pao[6:0] & ddra[6:0]; undriven bits read as off.
- Digit select: sel in 4..9 maps to digit index sel-4. All other codes are non-display.
- Input sampling: sel and seg are registered once. All decisions use the registered copies. Capture latency from the first stable cycle is STABLE_CYCLES+1 cycles.
- FSM states:
  - IDLE: registered sel is non-display. Go to SETTLE when it becomes a display code.
  - SETTLE: stable counter increments while {sel,seg} equals the previous cycle and resets to 0 on any change. At count STABLE_CYCLES-1, capture and go to HELD. A change to a non-display code goes to IDLE.
  - HELD: no further capture. Any change to {sel,seg} goes to SETTLE (counter 0), or to IDLE if the new code is non-display.
  - Stable counter saturates at STABLE_CYCLES-1.
- Capture: writes seg into slot d, sets digit_valid[d], reloads decay counter d to DECAY_CYCLES. Pulses frame_strobe for one cycle if d==5.
- Decay: each nonzero decay counter decrements by 1 per cycle. The transition 1->0 clears that slot's segments and valid bit.
- Simultaneous events:
  - Capture and expiry in the same cycle on the same slot: capture wins.
  - Other slots are unaffected by a capture.
- Capturing seg==0 is legal: valid=1 with blank segments.
- Reset asserted mid-scan clears everything immediately (async). After deassertion, the first capture needs a full STABLE_CYCLES dwell.

Optional Feature:
KIM1_KEYPAD_EN
- With the macro defined: adds input keys (21 bits, bit row*7+col, 1 = pressed) and output pai (8 bits, to RRIOT PAI).
  - Registered sel in 0..2 selects that row: pai[c] = ~keys[sel*7+c] for c 0..6, and pai[7] = 1.
  - Any other sel: pai = 8'hFF.
  - pai is registered, giving one cycle latency after registered sel. Reset value is 8'hFF.
- Without the macro: both ports are absent and display behaviour is identical.

Decomposition:
- Package kim1_pkg holds:
  - seg_t (logic [6:0])
  - sel_t (logic [3:0])
  - FSM enum cap_state_t {IDLE, SETTLE, HELD}
  - constants DIGIT_BASE=4, NUM_DIGITS=6, KEY_ROWS=3, KEY_COLS=7, SEL_NONE=4'hF
- Sub-module kim1_digit_slot, instantiated six times: one segment register, valid bit and decay counter, with inputs capture, seg_in and capture-over-expiry priority.

Test Plan:
- Reset then ddrb=8'h1E, pbo=8'h08 (sel 4), ddra=8'h7F, pao=8'h3F held 16 cycles: seg_out[6:0]=7'h3F and digit_valid=6'b000001 at cycle 17; no earlier capture.
- sel 9 with pao=8'h06 held 16 cycles: digit 5 captured, frame_strobe high exactly one cycle, seg_out[41:35]=7'h06.
- pao toggles every 8 cycles with STABLE_CYCLES=16: no capture and digit_valid unchanged; a hold of 16 identical cycles then captures.
- DECAY_CYCLES=100, capture digit 2 once and stop scanning: digit_valid[2] drops exactly 100 cycles after capture. Re-capture timed on the expiry cycle keeps it valid.
- ddrb=8'h00 with pbo=8'h08: sel=SEL_NONE, FSM stays IDLE, nothing captured. ddra=8'h0F with pao=8'hFF captures 7'h0F.
- With KIM1_KEYPAD_EN: sel 1, keys[9]=1 gives pai=8'hFB. sel 5 gives pai=8'hFF. Assert rst_n low mid-dwell: all outputs clear and pai=8'hFF.
